// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared complex-format helpers and width constants for the complex MAC
package cmul_pkg;

    localparam int MAX_W  = 32;
    localparam int CPLX_W = 2 * MAX_W;

    typedef logic signed [MAX_W-1:0] comp_t;
    typedef logic [CPLX_W-1:0]       cplx_t;

    function automatic int acc_width(input int w, input int guard);
        return 2 * w + 1 + guard;
    endfunction

    // Helpers operate on the widest supported format; callers zero-extend packed words.
    function automatic comp_t cplx_re(input cplx_t x, input int w);
        cplx_t t;
        t = x << (CPLX_W - 2 * w);
        return comp_t'($signed(t) >>> (CPLX_W - w));
    endfunction

    function automatic comp_t cplx_im(input cplx_t x, input int w);
        cplx_t t;
        t = x << (CPLX_W - w);
        return comp_t'($signed(t) >>> (CPLX_W - w));
    endfunction

    function automatic cplx_t cplx_pack(input comp_t re, input comp_t im, input int w);
        cplx_t m;
        m = (cplx_t'(1) << w) - cplx_t'(1);
        return ((cplx_t'(re) & m) << w) | (cplx_t'(im) & m);
    endfunction

    function automatic comp_t cplx_max(input int w);
        return comp_t'((64'sd1 <<< (w - 1)) - 64'sd1);
    endfunction

    function automatic comp_t cplx_min(input int w);
        return comp_t'(-(64'sd1 <<< (w - 1)));
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - round-half-up, fractional shift and clamp of one component
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int IN_W      = 21,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    // One extra bit so the rounding add cannot wrap at the top of the accumulator range.
    localparam int XW = IN_W + 1;
    localparam logic [XW-1:0]        RND  = (XW'(1) << FRAC_BITS) >> 1;
    localparam logic signed [XW-1:0] MAXV = XW'(cplx_max(OUT_W));
    localparam logic signed [XW-1:0] MINV = XW'(cplx_min(OUT_W));

    logic signed [XW-1:0] x;
    logic signed [XW-1:0] r;

    always_comb begin
        x    = XW'(din) + $signed(RND);
        r    = x >>> FRAC_BITS;
        sat  = 1'b0;
        dout = OUT_W'(r);
        if (r > MAXV) begin
            dout = OUT_W'(MAXV);
            sat  = 1'b1;
        end else if (r < MINV) begin
            dout = OUT_W'(MINV);
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/cmul_mac_pipe.sv
// rtl/cmul_mac_pipe.sv - 3-stage fixed-point complex multiplier / accumulator with valid/ready
module cmul_mac_pipe
    import cmul_pkg::*;
#(
    parameter int W         = 8,
    parameter int FRAC_BITS = 0,
    parameter int GUARD     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  a,
    input  logic [2*W-1:0]  b,
    input  logic            acc_mode,
    input  logic            in_first,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  res,
    output logic            sat
);

    localparam int PW    = 2 * W;
    localparam int ACC_W = acc_width(W, GUARD);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic signed [W-1:0] ra, ia, rb, ib;
    assign ra = W'(cplx_re(CPLX_W'(a), W));
    assign ia = W'(cplx_im(CPLX_W'(a), W));
    assign rb = W'(cplx_re(CPLX_W'(b), W));
    assign ib = W'(cplx_im(CPLX_W'(b), W));

    logic                 s1_valid, s1_acc, s1_first, s1_last;
    logic signed [PW-1:0] pp_rr, pp_ii, pp_ri, pp_ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_acc   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            pp_rr    <= '0;
            pp_ii    <= '0;
            pp_ri    <= '0;
            pp_ir    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_acc   <= acc_mode;
            s1_first <= in_first;
            s1_last  <= in_last;
            pp_rr    <= PW'(ra) * PW'(rb);
            pp_ii    <= PW'(ia) * PW'(ib);
            pp_ri    <= PW'(ra) * PW'(ib);
            pp_ir    <= PW'(ia) * PW'(rb);
        end
    end

    logic signed [ACC_W-1:0] prod_re, prod_im, sum_re, sum_im;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] s2_re, s2_im;
    logic                    s2_valid;

    assign prod_re = ACC_W'(pp_rr) - ACC_W'(pp_ii);
    assign prod_im = ACC_W'(pp_ri) + ACC_W'(pp_ir);
    assign sum_re  = (s1_first ? '0 : acc_re) + prod_re;
    assign sum_im  = (s1_first ? '0 : acc_im) + prod_im;

    // Only group-closing beats travel on; the rest leave a bubble in S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid && (!s1_acc || s1_last);
            s2_re    <= s1_acc ? sum_re : prod_re;
            s2_im    <= s1_acc ? sum_im : prod_im;
            if (s1_valid && s1_acc) begin
                acc_re <= sum_re;
                acc_im <= sum_im;
            end
        end
    end

    logic signed [W-1:0] q_re, q_im;
    logic                sat_re, sat_im;

    cmul_round_sat #(.IN_W(ACC_W), .OUT_W(W), .FRAC_BITS(FRAC_BITS)) u_rs_re (
        .din  (s2_re),
        .dout (q_re),
        .sat  (sat_re)
    );

    cmul_round_sat #(.IN_W(ACC_W), .OUT_W(W), .FRAC_BITS(FRAC_BITS)) u_rs_im (
        .din  (s2_im),
        .dout (q_im),
        .sat  (sat_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            sat       <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                res <= PW'(cplx_pack(comp_t'(q_re), comp_t'(q_im), W));
                sat <= sat_re || sat_im;
            end
        end
    end

endmodule

// File: tb/tb_cmul_mac_pipe.sv
// tb/tb_cmul_mac_pipe.sv - scoreboard bench for cmul_mac_pipe at FRAC_BITS 0, 4 and 7
module tb_cmul_mac_pipe;

    typedef struct {
        logic [15:0] r0;
        logic        s0;
        logic        chk_frac;
        logic [15:0] r4;
        logic        s4;
        logic [15:0] r7;
        logic        s7;
        logic        lat;
        int          acc_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, acc_mode, in_first, in_last, out_ready;
    logic [15:0] a, b;
    logic        rdy0, rdy4, rdy7, ov0, ov4, ov7, sat0, sat4, sat7;
    logic [15:0] res0, res4, res7;

    int   cyc    = 0;
    int   npass  = 0;
    int   ntotal = 0;
    exp_t sb[$];

    logic [15:0] bp_exp [6] = '{16'h0101, 16'h0204, 16'h0309, 16'h0410, 16'h0519, 16'h0624};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmul_mac_pipe #(.W(8), .FRAC_BITS(0), .GUARD(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
        .acc_mode(acc_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .res(res0), .sat(sat0));

    cmul_mac_pipe #(.W(8), .FRAC_BITS(4), .GUARD(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
        .acc_mode(acc_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(ov4), .out_ready(out_ready), .res(res4), .sat(sat4));

    cmul_mac_pipe #(.W(8), .FRAC_BITS(7), .GUARD(4)) dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy7), .a(a), .b(b),
        .acc_mode(acc_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(ov7), .out_ready(out_ready), .res(res7), .sat(sat7));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        ntotal++;
        if (act === want) npass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, want, cyc);
    endtask

    function automatic exp_t mk(input logic [15:0] r0, input logic s0, input logic [15:0] r4,
                                input logic s4, input logic [15:0] r7, input logic s7,
                                input logic chkf, input logic lat);
        exp_t e;
        e.r0 = r0; e.s0 = s0; e.r4 = r4; e.s4 = s4; e.r7 = r7; e.s7 = s7;
        e.chk_frac = chkf; e.lat = lat; e.acc_edge = 0;
        return e;
    endfunction

    function automatic exp_t none();
        return mk(16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic am,
                        input logic f, input logic l, input logic push, input exp_t e_in);
        exp_t e;
        int   g;
        e = e_in;
        @(negedge clk);
        a = ta; b = tb; acc_mode = am; in_first = f; in_last = l; in_valid = 1'b1;
        #1;
        g = 0;
        while (!rdy0 && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!rdy0) begin
            ntotal++;
            $display("FAIL accept_timeout: in_ready %b, required 1", rdy0);
        end
        e.acc_edge = cyc + 1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] held;
        logic        held_sat;
        logic        prev_stall;
        prev_stall = 1'b0;
        held       = '0;
        held_sat   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && ov0) begin
                    chk("hold_res", 32'(res0), 32'(held));
                    chk("hold_sat", 32'(sat0), 32'(held_sat));
                end
                if (ov0 && !out_ready) chk("stall_in_ready", 32'(rdy0), 32'd0);
                if (ov0 && out_ready) begin
                    if (sb.size() == 0) begin
                        ntotal++;
                        $display("FAIL unexpected_output: got res %h, required no output", res0);
                    end else begin
                        e = sb.pop_front();
                        chk("res", 32'(res0), 32'(e.r0));
                        chk("sat", 32'(sat0), 32'(e.s0));
                        chk("valid_frac", 32'({ov4, ov7}), 32'd3);
                        if (e.chk_frac) begin
                            chk("res_frac4", 32'(res4), 32'(e.r4));
                            chk("sat_frac4", 32'(sat4), 32'(e.s4));
                            chk("res_frac7", 32'(res7), 32'(e.r7));
                            chk("sat_frac7", 32'(sat7), 32'(e.s7));
                        end
                        if (e.lat) chk("latency", cyc - e.acc_edge, 32'd2);
                    end
                end
                prev_stall = ov0 && !out_ready;
                held       = res0;
                held_sat   = sat0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        acc_mode = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'({ov0, ov4, ov7}), 32'd0);
        chk("rst_res", 32'(res0), 32'd0);
        chk("rst_sat", 32'(sat0), 32'd0);
        chk("rst_in_ready", 32'({rdy0, rdy4, rdy7}), 32'd7);

        send(16'h0304, 16'h0102, 0, 0, 0, 1, mk(16'hFB0A, 0, 16'h0001, 0, 16'h0000, 0, 1, 1));
        send(16'h6400, 16'h0200, 0, 0, 0, 1, mk(16'h7F00, 1, 16'h0D00, 0, 16'h0200, 0, 1, 1));
        send(16'h8000, 16'h8000, 0, 0, 0, 1, mk(16'h7F00, 1, 16'h7F00, 1, 16'h7F00, 1, 1, 1));
        send(16'h0600, 16'h0400, 0, 0, 0, 1, mk(16'h1800, 0, 16'h0200, 0, 16'h0000, 0, 1, 1));
        send(16'hFA00, 16'h0400, 0, 0, 0, 1, mk(16'hE800, 0, 16'hFF00, 0, 16'h0000, 0, 1, 1));
        send(16'h8000, 16'h0200, 0, 0, 0, 1, mk(16'h8000, 1, 16'hF000, 0, 16'hFE00, 0, 1, 1));
        send(16'h0A0A, 16'h0A0A, 0, 0, 0, 1, mk(16'h007F, 1, 16'h000D, 0, 16'h0002, 0, 1, 1));
        send(16'h0304, 16'hFF02, 0, 0, 0, 1, mk(16'hF502, 0, 16'hFF00, 0, 16'h0000, 0, 1, 1));
        drain();

        for (int i = 0; i < 3; i++)
            send(16'h0101, 16'h0100, 1, i == 0, i == 2, i == 2,
                 mk(16'h0303, 0, 16'h0000, 0, 16'h0000, 0, 1, 1));
        drain();

        send(16'h0200, 16'h0300, 1, 1, 0, 0, none());
        send(16'h0304, 16'h0102, 0, 0, 0, 1, mk(16'hFB0A, 0, 16'h0001, 0, 16'h0000, 0, 1, 1));
        send(16'h0100, 16'h0400, 1, 0, 1, 1, mk(16'h0A00, 0, 16'h0100, 0, 16'h0000, 0, 1, 1));
        send(16'h0300, 16'h0300, 1, 1, 1, 1, mk(16'h0900, 0, 16'h0100, 0, 16'h0000, 0, 1, 1));
        for (int i = 0; i < 4; i++)
            send(16'h8000, 16'h8000, 1, i == 0, i == 3, i == 3,
                 mk(16'h7F00, 1, 16'h7F00, 1, 16'h7F00, 1, 1, 1));
        drain();

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send({8'(i + 1), 8'h00}, {8'h01, 8'(i + 1)}, 0, 0, 0, 1,
                         mk(bp_exp[i], 0, 16'h0, 0, 16'h0, 0, 0, 0));
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        send(16'h0500, 16'h0100, 1, 1, 0, 0, none());
        send(16'h0304, 16'h0102, 0, 0, 0, 0, none());
        send(16'h0600, 16'h0400, 0, 0, 0, 0, none());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("flush_out_valid", 32'(ov0), 32'd0);
        send(16'h0200, 16'h0100, 1, 0, 1, 1, mk(16'h0200, 0, 16'h0000, 0, 16'h0000, 0, 1, 1));
        drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
